// File: rtl/palette_cmd_pkg.sv
// Shared constants, command-word layout and types for the palette command generator.
package palette_cmd_pkg;

    localparam int unsigned CMD_W   = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned RGB_W   = 24;
    localparam int unsigned ENTRY_W = SLOT_W + RGB_W;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 11;
    localparam int unsigned SLOT_MSB = 10;
    localparam int unsigned SLOT_LSB = 6;
    localparam int unsigned RGB_BIT  = 5;

    localparam logic [OPC_W-1:0] OP_WRITE = 5'b10011;
    localparam logic [OPC_W-1:0] OP_HOLD  = 5'b11011;
    localparam logic [OPC_W-1:0] OP_CLEAR = 5'b00000;

    localparam logic [CMD_W-1:0] HOLD_CMD  = {OP_HOLD, 11'b0};
    localparam logic [CMD_W-1:0] CLEAR_CMD = {OP_CLEAR, 11'b0};

    typedef enum logic [1:0] {IDLE, CLR, RG, BX} state_t;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [RGB_W-1:0]  rgb;
    } req_entry_t;

    // Build a command word; low five bits are always zero.
    function automatic logic [CMD_W-1:0] make_cmd(input logic [OPC_W-1:0] opc,
                                                 input logic [SLOT_W-1:0] slot,
                                                 input logic half);
        logic [CMD_W-1:0] w;
        w = '0;
        w[OPC_MSB:OPC_LSB]   = opc;
        w[SLOT_MSB:SLOT_LSB] = slot;
        w[RGB_BIT]           = half;
        return w;
    endfunction

endpackage

// File: rtl/palette_req_fifo.sv
// Synchronous request FIFO with wrap-around pointers; a full FIFO refuses pushes even when popping.
module palette_req_fifo #(
    parameter int unsigned WIDTH = 29,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/palette_cmd_gen.sv
// Palette command initiator: queues RGB writes, merges clear requests, emits RG/BX write commands.
module palette_cmd_gen
    import palette_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SLOT_W-1:0]  req_slot,
    input  logic [RGB_W-1:0]   req_rgb,
    input  logic               clr_req,
    output logic [CMD_W-1:0]   cmd,
    output logic [DATA_W-1:0]  cmd_data,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               busy
);

    state_t                      state, state_next;
    logic [CMD_W-1:0]            cmd_next;
    logic [DATA_W-1:0]           data_next;
    logic                        valid_next;
    logic                        clr_pending, clr_next;
    logic                        accept;
    logic                        pop;
    logic                        full, empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    req_entry_t                  push_entry;
    req_entry_t                  head;

    assign push_entry = '{slot: req_slot, rgb: req_rgb};
    assign req_ready  = !full && !rst;
    assign accept     = cmd_valid && cmd_ready;
    assign busy       = (state != IDLE) || (count != '0) || clr_pending;

    palette_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Outputs are computed for the next state so they register alongside it.
    always_comb begin
        state_next = state;
        cmd_next   = cmd;
        data_next  = cmd_data;
        valid_next = cmd_valid;
        clr_next   = clr_pending || clr_req;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pending) begin
                    state_next = CLR;
                    cmd_next   = CLEAR_CMD;
                    data_next  = '0;
                    valid_next = 1'b1;
                end else if (!empty) begin
                    state_next = RG;
                    cmd_next   = make_cmd(OP_WRITE, head.slot, 1'b0);
                    data_next  = head.rgb[23:8];
                    valid_next = 1'b1;
                end else begin
                    cmd_next   = HOLD_CMD;
                    data_next  = '0;
                    valid_next = 1'b0;
                end
            end
            CLR: begin
                if (accept) begin
                    // A pulse landing on the accepting edge re-arms the clear.
                    clr_next   = clr_req;
                    state_next = IDLE;
                    cmd_next   = HOLD_CMD;
                    data_next  = '0;
                    valid_next = 1'b0;
                end
            end
            RG: begin
                if (accept) begin
                    state_next = BX;
                    cmd_next   = make_cmd(OP_WRITE, head.slot, 1'b1);
                    data_next  = {head.rgb[7:0], 8'h00};
                end
            end
            BX: begin
                if (accept) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                    cmd_next   = HOLD_CMD;
                    data_next  = '0;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                cmd_next   = HOLD_CMD;
                data_next  = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= HOLD_CMD;
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            clr_pending <= 1'b0;
        end else begin
            state       <= state_next;
            cmd         <= cmd_next;
            cmd_data    <= data_next;
            cmd_valid   <= valid_next;
            clr_pending <= clr_next;
        end
    end

endmodule

// File: tb/tb_palette_cmd_gen.sv
// Scoreboard bench for palette_cmd_gen: stimulus queues expected words, a monitor checks each handshake.
module tb_palette_cmd_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_slot;
    logic [23:0] req_rgb;
    logic        clr_req;
    logic [15:0] cmd;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    palette_cmd_gen #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_slot  (req_slot),
        .req_rgb   (req_rgb),
        .clr_req   (clr_req),
        .cmd       (cmd),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] w_rg(input logic [4:0] s, input logic [23:0] rgb);
        return {5'b10011, s, 1'b0, 5'b00000, rgb[23:8]};
    endfunction

    function automatic logic [31:0] w_bx(input logic [4:0] s, input logic [23:0] rgb);
        return {5'b10011, s, 1'b1, 5'b00000, rgb[7:0], 8'h00};
    endfunction

    // Monitor: handshakes pop the scoreboard; stalled words must not change.
    logic        hold_v = 1'b0;
    logic [31:0] hold_w = '0;
    always @(negedge clk) begin
        if (!rst && cmd_valid) begin
            if (hold_v) chk("stable", {cmd, cmd_data}, hold_w);
            if (cmd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd actual=%h required=none", {cmd, cmd_data});
                end else begin
                    chk("cmd_seq", {cmd, cmd_data}, exp_q.pop_front());
                end
                hold_v = 1'b0;
            end else begin
                hold_v = 1'b1;
                hold_w = {cmd, cmd_data};
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] s, input logic [23:0] rgb);
        bit done;
        done      = 1'b0;
        req_slot  = s;
        req_rgb   = rgb;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                tick();
                exp_q.push_back(w_rg(s, rgb));
                exp_q.push_back(w_bx(s, rgb));
                done = 1'b1;
            end
        end
        req_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL push_timeout actual=not_accepted required=accepted slot=%0d", s);
        end
    endtask

    task automatic pulse_clr(input bit expect_new);
        clr_req = 1'b1;
        if (expect_new) exp_q.push_back(32'h0000_0000);
        tick();
        clr_req = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL wait_valid actual=0 required=1");
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        chk({name, "_idle"}, {14'b0, cmd_valid, busy, cmd}, {14'b0, 1'b0, 1'b0, 16'hD800});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_slot  = '0;
        req_rgb   = '0;
        clr_req   = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_state", {13'b0, req_ready, cmd_valid, busy, cmd}, {13'b0, 3'b000, 16'hD800});
        chk("rst_data", {16'b0, cmd_data}, 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Single write with latency and post-entry idle checks.
        tick();
        cmd_ready = 1'b1;
        push(5'd5, 24'h123456);
        @(negedge clk);
        chk("lat_no_valid", {31'b0, cmd_valid}, 32'd0);
        @(negedge clk);
        chk("single_rg", {cmd, cmd_data}, 32'h9940_1234);
        chk("single_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("single_bx", {cmd, cmd_data}, 32'h9960_5600);
        @(negedge clk);
        chk("single_hold", {14'b0, cmd_valid, busy, cmd}, {14'b0, 1'b0, 1'b0, 16'hD800});
        drain("single");

        // Backpressure holds RG until the handshake.
        tick();
        cmd_ready = 1'b0;
        push(5'd9, 24'hA1B2C3);
        wait_valid();
        repeat (4) begin
            @(negedge clk);
            chk("bp_rg_hold", {cmd, cmd_data}, 32'h9A40_A1B2);
        end
        tick();
        cmd_ready = 1'b1;
        drain("bp");

        // FIFO full after four accepts while stalled.
        tick();
        cmd_ready = 1'b0;
        push(5'd1, 24'h111111);
        push(5'd2, 24'h222222);
        push(5'd3, 24'h333333);
        push(5'd4, 24'h444444);
        @(negedge clk);
        chk("full_ready0", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("full_ready0_hold", {31'b0, req_ready}, 32'd0);
        tick();
        cmd_ready = 1'b1;
        push(5'd6, 24'h666666);
        drain("full");

        // Clear pulsed twice during RG merges into one clear after the entry.
        tick();
        cmd_ready = 1'b0;
        push(5'd7, 24'h010203);
        wait_valid();
        chk("clr_entry_rg", {cmd, cmd_data}, 32'h99C0_0102);
        tick();
        pulse_clr(1'b1);
        tick();
        pulse_clr(1'b0);
        push(5'd8, 24'h0A0B0C);
        push(5'd10, 24'hDEADBE);
        tick();
        cmd_ready = 1'b1;
        drain("clr_merge");

        // Clear from idle: valid the cycle after the pending flag is set.
        tick();
        pulse_clr(1'b1);
        @(negedge clk);
        chk("clr_lat0", {30'b0, cmd_valid, busy}, 32'd1);
        @(negedge clk);
        chk("clr_cmd", {15'b0, cmd_valid, cmd}, {15'b0, 1'b1, 16'h0000});
        drain("clr_idle");

        // Reset during BX with two entries queued behind it.
        tick();
        cmd_ready = 1'b0;
        push(5'd3, 24'hAABBCC);
        push(5'd4, 24'hBBBBBB);
        push(5'd6, 24'hCCCCCC);
        wait_valid();
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_bx", {cmd, cmd_data}, 32'h98E0_CC00);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", {13'b0, req_ready, cmd_valid, busy, cmd}, {13'b0, 3'b100, 16'hD800});
        tick();
        cmd_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", {30'b0, cmd_valid, busy}, 32'd0);

        // Slot and colour boundary.
        tick();
        push(5'd31, 24'hFFFFFF);
        wait_valid();
        chk("slot31_rg", {cmd, cmd_data}, 32'h9FC0_FFFF);
        @(negedge clk);
        chk("slot31_bx", {cmd, cmd_data}, 32'h9FE0_FF00);
        drain("slot31");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
